draw_layer_sequencer: RTL and testbench
=======================================

Name: draw_layer_sequencer

Overview:
Parametrised frame compositor for the game view. On each `go` it steps through up to NUM_LAYERS draw engines in fixed priority order (background, items, hook, numbers, ...). For each enabled layer it starts the engine and forwards that engine's pixel stream to the single VGA write port, suppressing transparent pixels. It adds per-layer skip masks, a per-layer transparency enable, a stuck-engine watchdog and a frame-done handshake.

Parameters:
NUM_LAYERS, 6, number of layer engines; index 0 is drawn first.
X_W, 9, pixel X width.
Y_W, 8, pixel Y width.
C_W, 12, colour width.
KEY_COLOR, 0, colour value treated as transparent.
TIMEOUT_CYCLES, 131072, maximum cycles a layer may stay in DRAW without `layer_done`.
IDX_W, 3, width of the layer index; must satisfy 2^IDX_W >= NUM_LAYERS.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  1  start-frame request, sampled in IDLE only
layer_en  in  NUM_LAYERS  per-layer draw enable, latched on accepted go
trans_en  in  NUM_LAYERS  per-layer transparency enable, latched on accepted go
layer_start  out  NUM_LAYERS  one-cycle start pulse to engine i
layer_done  in  NUM_LAYERS  engine i finished
layer_x  in  NUM_LAYERS*X_W  packed X buses; layer i uses bits [i*X_W +: X_W]
layer_y  in  NUM_LAYERS*Y_W  packed Y buses
layer_color  in  NUM_LAYERS*C_W  packed colour buses
layer_we  in  NUM_LAYERS  per-layer pixel valid
X_out  out  X_W  registered pixel X
Y_out  out  Y_W  registered pixel Y
Color_out  out  C_W  registered pixel colour
writeEn  out  1  registered write strobe
busy  out  1  high whenever state is not IDLE
cur_layer  out  IDX_W  index of the layer currently selected
frame_done  out  1  one-cycle pulse at end of frame
timeout_err  out  1  sticky flag; cleared on accepted go
timeout_layer  out  IDX_W  index of the last layer that timed out

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0, including X/Y/Color_out, writeEn, layer_start, timeout_err and cur_layer. Latched masks and the watchdog counter clear. Reset in any state aborts the frame with no frame_done.
- States: IDLE, SEL, START, DRAW, NEXT, DONE.
- IDLE: go=1 latches `layer_en`/`trans_en`, clears timeout_err, sets cur_layer=0 and moves to SEL. go=0 holds IDLE. go is ignored in every other state.
- SEL: if the latched enable bit for cur_layer is set, go to START; otherwise go to NEXT.
- START: drive layer_start[cur_layer]=1 for exactly this cycle, clear the watchdog, go to DRAW.
- DRAW:
  - Forward only the selected layer; writes and done signals from other layers are ignored.
  - Watchdog increments each cycle.
  - layer_done[cur_layer]=1 moves to NEXT.
  - Watchdog reaching TIMEOUT_CYCLES-1 without done moves to NEXT, sets timeout_err=1 and timeout_layer=cur_layer.
  - If done and timeout coincide, done wins: no error is flagged.
- NEXT: if cur_layer==NUM_LAYERS-1, go to DONE; otherwise cur_layer+1 and go to SEL. Skipped layers cost 2 cycles each (SEL + NEXT).
- DONE: frame_done=1 for one cycle, then IDLE. cur_layer holds its last value.
- Pixel path has 1-cycle latency. On the clock edge where the registered state is DRAW:
  - X/Y/Color_out load the selected layer's buses.
  - writeEn <= layer_we[cur] & ~(trans_en_latched[cur] & (layer_color[cur]==KEY_COLOR)).
  - Transparency is judged on the incoming colour, never the previously registered one.
- A pixel presented in the same cycle as layer_done is still forwarded.
- Outside DRAW, writeEn <= 0 and X/Y/Color_out hold their values.
- All-zero layer_en: frame walks SEL/NEXT for every layer, emits no start pulses, and still produces frame_done.

Test Plan:
- NUM_LAYERS=3, layer_en=3'b111, each engine writes 4 pixels then done. Required: exactly 3 start pulses in order 0,1,2; 12 writes, each 1 cycle after its input; frame_done once; busy falls the cycle after frame_done.
- Layer 1 trans_en=1 with colours 0x000, 0xF00, 0x000, 0x0F0. Required: writeEn only for 0xF00 and 0x0F0. Same colours with trans_en=0: all 4 written.
- layer_en=3'b101. Required: no layer_start[1]; layer 1 `layer_we` toggling while layer 0 draws produces no writes; frame_done reached.
- TIMEOUT_CYCLES=16, layer 2 never asserts done. Required: DRAW leaves after 16 cycles; timeout_err=1, timeout_layer=2; frame_done still pulses. Next go clears timeout_err.
- go pulsed during DRAW. Required: ignored. resetn low mid-DRAW: all outputs 0 immediately (asynchronously); no frame_done; next go restarts at layer 0.
- layer_done and layer_we high in the same cycle with colour 0xABC. Required: that pixel written (writeEn=1, Color_out=0xABC), then next layer started.

Source files
------------

// File: rtl/draw_layer_sequencer.sv
// Frame compositor: walks the layer engines in fixed priority order, starts each
// enabled engine and forwards its pixel stream to the single VGA write port.
module draw_layer_sequencer #(
  parameter int              NUM_LAYERS     = 6,
  parameter int              X_W            = 9,
  parameter int              Y_W            = 8,
  parameter int              C_W            = 12,
  parameter logic [C_W-1:0]  KEY_COLOR      = '0,
  parameter int              TIMEOUT_CYCLES = 131072,
  parameter int              IDX_W          = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      go,
  input  logic [NUM_LAYERS-1:0]     layer_en,
  input  logic [NUM_LAYERS-1:0]     trans_en,
  output logic [NUM_LAYERS-1:0]     layer_start,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic [NUM_LAYERS*X_W-1:0] layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0] layer_y,
  input  logic [NUM_LAYERS*C_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]     layer_we,
  output logic [X_W-1:0]            X_out,
  output logic [Y_W-1:0]            Y_out,
  output logic [C_W-1:0]            Color_out,
  output logic                      writeEn,
  output logic                      busy,
  output logic [IDX_W-1:0]          cur_layer,
  output logic                      frame_done,
  output logic                      timeout_err,
  output logic [IDX_W-1:0]          timeout_layer
);

  localparam int                    WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    START = 3'd2,
    DRAW  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cur_q, cur_d;
  logic [NUM_LAYERS-1:0]   en_q, en_d;
  logic [NUM_LAYERS-1:0]   te_q, te_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic                    terr_q, terr_d;
  logic [IDX_W-1:0]        tlayer_q, tlayer_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [C_W-1:0]          c_q, c_d;
  logic                    we_q, we_d;

  logic [X_W-1:0]          sel_x;
  logic [Y_W-1:0]          sel_y;
  logic [C_W-1:0]          sel_c;
  logic                    sel_we, sel_done, sel_en, sel_te;

  // Only the layer addressed by cur_q reaches the pixel path or the FSM.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_we   = 1'b0;
    sel_done = 1'b0;
    sel_en   = 1'b0;
    sel_te   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cur_q == IDX_W'(i)) begin
        sel_x    = layer_x[i*X_W +: X_W];
        sel_y    = layer_y[i*Y_W +: Y_W];
        sel_c    = layer_color[i*C_W +: C_W];
        sel_we   = layer_we[i];
        sel_done = layer_done[i];
        sel_en   = en_q[i];
        sel_te   = te_q[i];
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    en_d        = en_q;
    te_d        = te_q;
    wdog_d      = wdog_q;
    terr_d      = terr_q;
    tlayer_d    = tlayer_q;
    x_d         = x_q;
    y_d         = y_q;
    c_d         = c_q;
    we_d        = 1'b0;
    layer_start = '0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          en_d    = layer_en;
          te_d    = trans_en;
          terr_d  = 1'b0;
          cur_d   = '0;
          state_d = SEL;
        end
      end
      SEL: state_d = sel_en ? START : NEXT;
      START: begin
        layer_start = ONE_HOT0 << cur_q;
        wdog_d      = '0;
        state_d     = DRAW;
      end
      DRAW: begin
        // Transparency uses the incoming colour, not the registered one.
        x_d    = sel_x;
        y_d    = sel_y;
        c_d    = sel_c;
        we_d   = sel_we & ~(sel_te & (sel_c == KEY_COLOR));
        wdog_d = wdog_q + WD_W'(1);
        if (sel_done) begin
          state_d = NEXT;
        end else if (wdog_q == WD_LAST) begin
          state_d  = NEXT;
          terr_d   = 1'b1;
          tlayer_d = cur_q;
        end
      end
      NEXT: begin
        if (cur_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cur_d   = cur_q + IDX_W'(1);
          state_d = SEL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      en_q     <= '0;
      te_q     <= '0;
      wdog_q   <= '0;
      terr_q   <= 1'b0;
      tlayer_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      en_q     <= en_d;
      te_q     <= te_d;
      wdog_q   <= wdog_d;
      terr_q   <= terr_d;
      tlayer_q <= tlayer_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      we_q     <= we_d;
    end
  end

  assign X_out         = x_q;
  assign Y_out         = y_q;
  assign Color_out     = c_q;
  assign writeEn       = we_q;
  assign busy          = (state_q != IDLE);
  assign cur_layer     = cur_q;
  assign frame_done    = (state_q == DONE);
  assign timeout_err   = terr_q;
  assign timeout_layer = tlayer_q;

endmodule

// File: tb/tb_draw_layer_sequencer.sv
// Self-checking bench for draw_layer_sequencer: 3 layers, 16-cycle watchdog.
module tb_draw_layer_sequencer;

  localparam int NL = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 12;
  localparam int TO = 16;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              go = 1'b0;
  logic [NL-1:0]     layer_en = '0;
  logic [NL-1:0]     trans_en = '0;
  logic [NL-1:0]     layer_start;
  logic [NL-1:0]     layer_done = '0;
  logic [NL*XW-1:0]  layer_x = '0;
  logic [NL*YW-1:0]  layer_y = '0;
  logic [NL*CW-1:0]  layer_color = '0;
  logic [NL-1:0]     layer_we = '0;
  logic [XW-1:0]     X_out;
  logic [YW-1:0]     Y_out;
  logic [CW-1:0]     Color_out;
  logic              writeEn;
  logic              busy;
  logic [IW-1:0]     cur_layer;
  logic              frame_done;
  logic              timeout_err;
  logic [IW-1:0]     timeout_layer;

  draw_layer_sequencer #(
    .NUM_LAYERS(NL), .X_W(XW), .Y_W(YW), .C_W(CW),
    .KEY_COLOR(12'h000), .TIMEOUT_CYCLES(TO), .IDX_W(IW)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go),
    .layer_en(layer_en), .trans_en(trans_en),
    .layer_start(layer_start), .layer_done(layer_done),
    .layer_x(layer_x), .layer_y(layer_y), .layer_color(layer_color),
    .layer_we(layer_we),
    .X_out(X_out), .Y_out(Y_out), .Color_out(Color_out), .writeEn(writeEn),
    .busy(busy), .cur_layer(cur_layer), .frame_done(frame_done),
    .timeout_err(timeout_err), .timeout_layer(timeout_layer)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          we;
    logic          done;
    logic [CW-1:0] color;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    layer_done  = '0;
    layer_we    = '0;
    layer_x     = '0;
    layer_y     = '0;
    layer_color = '0;
  endtask

  task automatic drive_pix(input int l, input logic w, input logic d,
                           input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c);
    layer_we[l]            = w;
    layer_done[l]          = d;
    layer_x[l*XW +: XW]    = x;
    layer_y[l*YW +: YW]    = y;
    layer_color[l*CW +: CW] = c;
  endtask

  task automatic wait_start(input int l, input string name);
    int n;
    n = 0;
    while (layer_start[l] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, layer_start[l], 1);
  endtask

  // Serves any started engine with a one-cycle done and runs to frame_done.
  task automatic finish_frame(input string name);
    logic [NL-1:0] pend;
    int n;
    int fd;
    pend = '0;
    n = 0;
    fd = 0;
    while (n < 100) begin
      layer_done = pend;
      pend = layer_start;
      if (frame_done === 1'b1) begin
        fd = 1;
        break;
      end
      tick();
      n++;
    end
    clear_inputs();
    check(name, fd, 1);
    tick();
  endtask

  task automatic apply_group(input int lo, input int hi, input logic [NL-1:0] en,
                             input logic [NL-1:0] te);
    layer_en = en;
    trans_en = te;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(1, $sformatf("grp%0d_start1", lo));
    tick();
    drive_pix(1, vecs[lo].we, vecs[lo].done, vecs[lo].x, vecs[lo].y, vecs[lo].color);
    for (int i = lo; i <= hi; i++) begin
      tick();
      check($sformatf("vec%0d_we", i), writeEn, vecs[i].exp_we);
      check($sformatf("vec%0d_color", i), Color_out, vecs[i].color);
      check($sformatf("vec%0d_xy", i), {X_out, Y_out}, {vecs[i].x, vecs[i].y});
      clear_inputs();
      if (i < hi)
        drive_pix(1, vecs[i+1].we, vecs[i+1].done, vecs[i+1].x, vecs[i+1].y, vecs[i+1].color);
    end
  endtask

  // Engine model: each started engine writes 4 pixels then signals done, unless
  // it is marked as hung, in which case it writes forever and never finishes.
  task automatic run_frame(input string name, input logic [NL-1:0] en,
                           input logic [NL-1:0] te, input logic [NL-1:0] hang,
                           input bit toggle, input bit done_last, input int exp_writes,
                           input logic [IW-1:0] exp_tl, input bit exp_terr);
    int act, dcnt, writes, bad, fd, cyc, mism, idx;
    int order[$];
    logic ew;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [CW-1:0] ec;
    act = -1; dcnt = 0; writes = 0; bad = 0; fd = 0; cyc = 0;
    ew = 1'b0; ex = '0; ey = '0; ec = '0;
    layer_en = en;
    trans_en = te;
    go = 1'b1;
    tick();
    go = 1'b0;
    check({name, "_busy_on_go"}, busy, 1);
    check({name, "_terr_cleared"}, timeout_err, 0);
    check({name, "_cur0"}, cur_layer, 0);
    while (cyc < 400 && fd == 0) begin
      if (writeEn !== ew) bad++;
      else if (ew && (X_out !== ex || Y_out !== ey || Color_out !== ec)) bad++;
      if (writeEn === 1'b1) writes++;
      if (frame_done === 1'b1) fd = 1;
      clear_inputs();
      if (toggle) begin
        for (int j = 0; j < NL; j++)
          drive_pix(j, cyc[0], cyc[1], 9'h1FF, 8'hEE, 12'h555);
      end
      ew = 1'b0;
      if (act >= 0) begin
        logic stuck, w, d;
        logic [CW-1:0] c;
        stuck = hang[act];
        c = CW'(256 * (act + 1) + dcnt + 1);
        w = stuck || (dcnt < 4);
        d = !stuck && (done_last ? (dcnt == 3) : (dcnt == 4));
        ex = XW'(act * 50 + dcnt);
        ey = YW'(dcnt);
        ec = c;
        drive_pix(act, w, d, ex, ey, c);
        ew = w && (!stuck || dcnt < TO) && !(te[act] && c == 12'h000);
        dcnt++;
        if (d) act = -1;
      end
      if (layer_start !== '0) begin
        for (int j = 0; j < NL; j++) begin
          if (layer_start[j] === 1'b1) begin
            order.push_back(j);
            act = j;
            dcnt = 0;
          end
        end
      end
      tick();
      cyc++;
    end
    clear_inputs();
    check({name, "_frame_done"}, fd, 1);
    check({name, "_busy_after_done"}, busy, 0);
    check({name, "_done_one_cycle"}, frame_done, 0);
    check({name, "_writes"}, writes, exp_writes);
    check({name, "_pixel_errs"}, bad, 0);
    mism = 0;
    idx = 0;
    for (int j = 0; j < NL; j++) begin
      if (en[j]) begin
        if (order.size() <= idx || order[idx] != j) mism++;
        idx++;
      end
    end
    check({name, "_start_count"}, order.size(), $countones(en));
    check({name, "_start_order"}, mism, 0);
    check({name, "_timeout_err"}, timeout_err, exp_terr);
    check({name, "_timeout_layer"}, timeout_layer, exp_tl);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pix"}, {X_out, Y_out, Color_out, writeEn}, 0);
    check({name, "_ctrl"}, {busy, cur_layer, frame_done, layer_start}, 0);
    check({name, "_terr"}, {timeout_err, timeout_layer}, 0);
  endtask

  initial begin
    int fdc;
    logic [11:0] cols[5];
    logic        weA[5];
    logic        expA[5];
    logic        doneA[5];

    cols  = '{12'h000, 12'hF00, 12'h000, 12'h0F0, 12'h123};
    weA   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expA  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    doneA = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      vecs[i] = '{weA[i], doneA[i], cols[i], XW'(3*i + 1), YW'(100 + i), expA[i]};
      vecs[i+5] = '{1'b1, doneA[i], cols[i], XW'(3*i + 2), YW'(120 + i), 1'b1};
    end
    vecs[9].color = 12'hABC;

    tick();
    tick();
    check_all_zero("reset");
    resetn = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    run_frame("full", 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 12, 3'd0, 1'b0);

    apply_group(0, 4, 3'b010, 3'b010);
    finish_frame("grpA_done");
    apply_group(5, 9, 3'b110, 3'b000);
    wait_start(2, "coincident_next_start2");
    finish_frame("grpB_done");

    run_frame("hang", 3'b111, 3'b000, 3'b100, 1'b0, 1'b0, 24, 3'd2, 1'b1);
    tick();
    tick();
    check("terr_sticky_idle", timeout_err, 1);

    run_frame("skip", 3'b101, 3'b000, 3'b000, 1'b1, 1'b0, 8, 3'd2, 1'b0);
    run_frame("done_last", 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 12, 3'd2, 1'b0);

    layer_en = 3'b111;
    trans_en = 3'b000;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(0, "rst_start0");
    tick();
    drive_pix(0, 1'b0, 1'b1, '0, '0, '0);
    tick();
    clear_inputs();
    wait_start(1, "rst_start1");
    tick();
    go = 1'b1;
    drive_pix(1, 1'b1, 1'b0, 9'd77, 8'd33, 12'hABC);
    tick();
    go = 1'b0;
    check("go_ignored_cur", cur_layer, 1);
    check("go_ignored_busy", busy, 1);
    check("pre_rst_pixel", {writeEn, Color_out}, {1'b1, 12'hABC});
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    clear_inputs();
    fdc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (frame_done !== 1'b0) fdc++;
    end
    check("no_frame_done_in_reset", fdc, 0);
    resetn = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("restart_cur0", cur_layer, 0);
    tick();
    check("restart_start0", layer_start, 3'b001);
    finish_frame("restart_done");

    run_frame("none", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, failed=%0d", n_fail);
    $fatal(1);
  end

endmodule
